// File: rtl/axis_downsizer.sv
// -----------------------------------------------------------------------------
// axis_downsizer
//
// Splits each wide AXI-Stream beat (S_WORDS words, per-word keep) into
// RATIO = S_WORDS/M_WORDS narrower pieces of M_WORDS words. Word 0 of the
// input beat leaves first. Pieces above the highest piece that carries any
// keep bit are skipped. A beat with all keep bits clear still produces one
// piece (keep all zero) so its last flag is not lost.
//
// Ports
//   aclk      in   clock, rising edge
//   aresetn   in   asynchronous active-low reset
//   s_ready   out  input ready (combinational on m_ready for back-to-back)
//   s_valid   in   input valid
//   s_last    in   input end-of-packet
//   s_data    in   S_WORDS*WORD_WIDTH input words, word i at slice i
//   s_keep    in   per-word keep, contiguous from bit 0
//   m_ready   in   output ready
//   m_valid   out  output valid (registered)
//   m_last    out  output end-of-packet, only on the final emitted piece
//   m_data    out  M_WORDS*WORD_WIDTH output words
//   m_keep    out  per-word keep of the current piece
// -----------------------------------------------------------------------------
module axis_downsizer #(
   parameter int WORD_WIDTH = 16,
   parameter int S_WORDS    = 4,
   parameter int M_WORDS    = 1
) (
   input  logic                          aclk,
   input  logic                          aresetn,
   output logic                          s_ready,
   input  logic                          s_valid,
   input  logic                          s_last,
   input  logic [S_WORDS*WORD_WIDTH-1:0] s_data,
   input  logic [S_WORDS-1:0]            s_keep,
   input  logic                          m_ready,
   output logic                          m_valid,
   output logic                          m_last,
   output logic [M_WORDS*WORD_WIDTH-1:0] m_data,
   output logic [M_WORDS-1:0]            m_keep
);

   localparam int RATIO = S_WORDS / M_WORDS;
   localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam int PW    = M_WORDS * WORD_WIDTH;

   generate
      if ((M_WORDS < 1) || (S_WORDS % M_WORDS != 0)) begin : g_bad_ratio
         $error("axis_downsizer: S_WORDS must be a non-zero multiple of M_WORDS");
      end
   endgenerate

   // Index of the highest piece holding any kept word; 0 when keep is empty,
   // which makes an empty beat emit exactly one piece.
   function automatic logic [IDX_W-1:0] top_piece(input logic [S_WORDS-1:0] keep);
      logic [IDX_W-1:0] n;
      n = '0;
      for (int p = 0; p < RATIO; p++) begin
         if (|keep[p*M_WORDS +: M_WORDS]) n = IDX_W'(p);
      end
      return n;
   endfunction

   logic [S_WORDS*WORD_WIDTH-1:0] data_q, data_d;
   logic [S_WORDS-1:0]            keep_q, keep_d;
   logic                          last_q, last_d;
   logic                          full_q, full_d;
   logic [IDX_W-1:0]              idx_q, idx_d;
   logic [IDX_W-1:0]              npc_q, npc_d;

   logic out_hs;
   logic at_last;
   logic load;

   always_comb begin
      out_hs  = full_q && m_ready;
      at_last = (idx_q == npc_q);
      // A new beat may enter while the final piece of the current one leaves.
      s_ready = aresetn && (!full_q || (out_hs && at_last));
      load    = s_valid && s_ready;

      data_d = data_q;
      keep_d = keep_q;
      last_d = last_q;
      full_d = full_q;
      idx_d  = idx_q;
      npc_d  = npc_q;

      if (load) begin
         data_d = s_data;
         keep_d = s_keep;
         last_d = s_last;
         full_d = 1'b1;
         idx_d  = '0;
         npc_d  = top_piece(s_keep);
      end else if (out_hs) begin
         if (at_last) begin
            full_d = 1'b0;
         end else begin
            idx_d = idx_q + IDX_W'(1);
         end
      end
   end

   always_comb begin
      m_data = '0;
      m_keep = '0;
      for (int p = 0; p < RATIO; p++) begin
         if (idx_q == IDX_W'(p)) begin
            m_data = data_q[p*PW +: PW];
            m_keep = keep_q[p*M_WORDS +: M_WORDS];
         end
      end
      m_valid = full_q;
      m_last  = full_q && last_q && at_last;
   end

   // Holding register: data is cleared too so outputs read zero in reset.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         data_q <= '0;
         keep_q <= '0;
         last_q <= 1'b0;
         full_q <= 1'b0;
         idx_q  <= '0;
         npc_q  <= '0;
      end else begin
         data_q <= data_d;
         keep_q <= keep_d;
         last_q <= last_d;
         full_q <= full_d;
         idx_q  <= idx_d;
         npc_q  <= npc_d;
      end
   end

endmodule

// File: doc/axis_downsizer.md
# axis_downsizer

Converts a wide AXI-Stream (S_WORDS words per beat, per-word keep) into a narrower AXI-Stream (M_WORDS words per beat) with no loss of data, keep or last information. It sits between a wide stream producer (e.g. the DMA/file source driving the engine input at BUS_WIDTH) and a narrower consumer, and runs at full output throughput under back-to-back input. Word 0 of an input beat is emitted first, matching the file/word order used by the stream benches.

## Interface
- WORD_WIDTH, 16, bits per word
- S_WORDS, 4, words per input beat
- M_WORDS, 1, words per output beat; S_WORDS % M_WORDS must be 0 (elaboration error otherwise)
- RATIO, S_WORDS/M_WORDS, derived: pieces per input beat

- aclk  in  1  clock, all logic on rising edge
- aresetn  in  1  asynchronous, active-low reset
- s_ready  out  1  input ready
- s_valid  in  1  input valid
- s_last  in  1  input end-of-packet
- s_data  in  S_WORDS×WORD_WIDTH  input words, word i at [i]
- s_keep  in  S_WORDS  per-word keep; set bits form a contiguous run from bit 0
- m_ready  in  1  output ready
- m_valid  out  1  output valid
- m_last  out  1  output end-of-packet
- m_data  out  M_WORDS×WORD_WIDTH  output words
- m_keep  out  M_WORDS  per-word keep

## Operation
- State: holding register (data, keep, last), `full` flag, piece index `idx` (0..RATIO-1), `n_pieces` = index of highest piece with any keep bit set (0 if keep all zero).
- Reset (async): full=0, idx=0; m_valid=0, m_last=0, m_data=0, m_keep=0. s_ready=0 while aresetn low; s_ready=1 first cycle after release.
- s_ready = !full || (m_valid && m_ready && idx==n_pieces) — combinational, enables back-to-back beats.
- Input handshake (s_valid && s_ready): load holding register, full=1, idx=0, compute n_pieces from s_keep.
- Output piece idx: m_data = held words [idx*M_WORDS +: M_WORDS], m_keep = held keep slice, m_valid = full.
- m_last = held last && idx==n_pieces; never asserted on earlier pieces.
- Output handshake: idx<n_pieces → idx+1; idx==n_pieces → full=0 unless a new beat loads same cycle (load wins, idx=0).
- Pieces above n_pieces are skipped (never emitted).
- All-zero keep beat: emitted as exactly one piece with m_keep=0, m_last=s_last (preserves packet termination).
- RATIO=1: pure one-deep register slice, same rules.

## Timing
- Latency: input handshake at edge N → m_valid high after edge N, piece 0 handshakeable at edge N+1.
- Throughput: a beat with k valid pieces occupies k output cycles; with m_ready=1 and s_valid held, zero bubbles between beats.
- While m_valid && !m_ready: m_data, m_keep, m_last held stable (AXIS rule); idx does not advance.
- s_valid low or data changing while s_ready=0 has no effect; nothing sampled without handshake.
- Reset mid-packet: held beat discarded, outputs to reset values immediately; no stale piece after release.
- m_valid does not depend combinationally on m_ready; s_ready depends combinationally on m_ready only.

## Test plan
- WORD_WIDTH=16, S_WORDS=4, M_WORDS=1, m_ready=1: beat {3,2,1,0} keep 1111 last 0 → m_data 0,1,2,3 on 4 consecutive cycles, m_keep=1, m_last=0; s_ready low for 3 of those cycles.
- Tail beat {x,x,9,8} keep 0011 last 1 → exactly two pieces 8 then 9; m_last=1 only with 9; pieces 2,3 never emitted.
- Back-to-back: beats {3,2,1,0},{7,6,5,4} with s_valid held, m_ready=1 → 0..7 on 8 consecutive cycles, second beat accepted on the cycle piece 3 handshakes.
- Random stress: source PROB_VALID=5, sink PROB_READY=20, 202 words 0..201 written via file → output file reads 0..201 in order, single m_last on 201; checker flags any m_data/m_keep/m_last change while m_valid && !m_ready.
- Reset mid-packet: drop aresetn after 2 of 4 pieces → m_valid=0 without clock edge; after release s_ready=1, next beat {13,12,11,10} outputs 10..13 only.
- Zero-keep last beat (keep 0000, last 1) → one piece m_keep=0, m_last=1; also M_WORDS=2: beat {3,2,1,0} keep 0111 → {1,0} keep 11, then {x,2} keep 01 with m_last per s_last.
